// File: rtl/simple_uart.sv
// rtl/simple_uart.sv - minimal 8N1 UART with single-byte receive buffer and transmitter
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous active-high reset
//   ser_rx         - asynchronous serial input, idle high
//   ser_tx         - serial output, idle high
//   reg_dat_re     - read strobe, consumes the buffered byte
//   reg_dat_do     - last received byte
//   recv_buf_valid - buffered byte is unread
//   reg_dat_we     - write strobe, starts transmission of reg_dat_di
//   reg_dat_di     - byte to transmit
//   tx_busy        - transmitter is shifting a frame
module simple_uart #(
    parameter int CLOCK_FREQUENCY = 16000000,
    parameter int BAUD_RATE       = 31250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_rx,
    output logic       ser_tx,
    input  logic       reg_dat_re,
    output logic [7:0] reg_dat_do,
    output logic       recv_buf_valid,
    input  logic       reg_dat_we,
    input  logic [7:0] reg_dat_di,
    output logic       tx_busy
);

    localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW  = $clog2(DIV);

    // Counters load N-1 and expire at zero, so a load of DIV_M1 spans exactly DIV cycles.
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    uart_state_t   rx_state,  rx_state_next;
    logic [CW-1:0] rx_cnt,    rx_cnt_next;
    logic [2:0]    rx_bits,   rx_bits_next;
    logic [7:0]    rx_shift,  rx_shift_next;
    logic          rx_done;

    // Synchroniser flops and the edge-detect history reset to the idle line level
    // so that leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bits_next  = rx_bits;
        rx_shift_next = rx_shift;
        rx_done       = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_next = S_START;
                    rx_cnt_next   = HALF_M1;
                end
            end
            S_START: begin
                if (rx_cnt == '0) begin
                    // Mid start bit: a high line here means the edge was a glitch.
                    if (!rx_sync) begin
                        rx_state_next = S_DATA;
                        rx_cnt_next   = DIV_M1;
                        rx_bits_next  = 3'd0;
                    end else begin
                        rx_state_next = S_IDLE;
                    end
                end else begin
                    rx_cnt_next = rx_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    rx_cnt_next   = DIV_M1;
                    if (rx_bits == 3'd7) begin
                        rx_state_next = S_STOP;
                    end else begin
                        rx_bits_next = rx_bits + 3'd1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt == '0) begin
                    rx_done       = rx_sync;
                    rx_state_next = S_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt - CW'(1);
                end
            end
            default: begin
                rx_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_bits  <= rx_bits_next;
            rx_shift <= rx_shift_next;
        end
    end

    // A completing byte takes priority over a read in the same cycle, so the
    // consumer never loses a byte it has not yet seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_dat_do     <= 8'h00;
            recv_buf_valid <= 1'b0;
        end else if (rx_done) begin
            reg_dat_do     <= rx_shift;
            recv_buf_valid <= 1'b1;
        end else if (reg_dat_re) begin
            recv_buf_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t   tx_state, tx_state_next;
    logic [CW-1:0] tx_cnt,   tx_cnt_next;
    logic [2:0]    tx_bits,  tx_bits_next;
    logic [7:0]    tx_shift, tx_shift_next;
    logic          ser_tx_next;
    logic          tx_busy_next;

    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bits_next  = tx_bits;
        tx_shift_next = tx_shift;
        case (tx_state)
            S_IDLE: begin
                if (reg_dat_we) begin
                    tx_state_next = S_START;
                    tx_cnt_next   = DIV_M1;
                    tx_shift_next = reg_dat_di;
                end
            end
            S_START: begin
                if (tx_cnt == '0) begin
                    tx_state_next = S_DATA;
                    tx_cnt_next   = DIV_M1;
                    tx_bits_next  = 3'd0;
                end else begin
                    tx_cnt_next = tx_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_next = DIV_M1;
                    if (tx_bits == 3'd7) begin
                        tx_state_next = S_STOP;
                    end else begin
                        tx_bits_next  = tx_bits + 3'd1;
                        tx_shift_next = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_next = tx_cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_next = S_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt - CW'(1);
                end
            end
            default: begin
                tx_state_next = S_IDLE;
            end
        endcase
    end

    // Line level and busy flag are derived from the next state so they are
    // registered and change on the same edge as the state itself.
    always_comb begin
        ser_tx_next  = 1'b1;
        tx_busy_next = (tx_state_next != S_IDLE);
        case (tx_state_next)
            S_START: ser_tx_next = 1'b0;
            S_DATA:  ser_tx_next = tx_shift_next[0];
            default: ser_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= 3'd0;
            tx_shift <= 8'h00;
            ser_tx   <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bits  <= tx_bits_next;
            tx_shift <= tx_shift_next;
            ser_tx   <= ser_tx_next;
            tx_busy  <= tx_busy_next;
        end
    end

endmodule

// File: tb/tb_simple_uart.sv
// tb/tb_simple_uart.sv - self-checking bench for simple_uart
module tb_simple_uart;

    localparam int DIV_A = 512;

    logic       clk;
    logic       reset;

    logic       ser_rx_a;
    logic       ser_tx_a;
    logic       reg_dat_re_a;
    logic [7:0] reg_dat_do_a;
    logic       recv_buf_valid_a;
    logic       reg_dat_we_a;
    logic [7:0] reg_dat_di_a;
    logic       tx_busy_a;

    logic       ser_tx_b;
    logic       reg_dat_re_b;
    logic [7:0] reg_dat_do_b;
    logic       recv_buf_valid_b;
    logic       reg_dat_we_b;
    logic [7:0] reg_dat_di_b;
    logic       tx_busy_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic       txb_q[$];

    simple_uart #(.CLOCK_FREQUENCY(16000000), .BAUD_RATE(31250)) dut_a (
        .clk            (clk),
        .reset          (reset),
        .ser_rx         (ser_rx_a),
        .ser_tx         (ser_tx_a),
        .reg_dat_re     (reg_dat_re_a),
        .reg_dat_do     (reg_dat_do_a),
        .recv_buf_valid (recv_buf_valid_a),
        .reg_dat_we     (reg_dat_we_a),
        .reg_dat_di     (reg_dat_di_a),
        .tx_busy        (tx_busy_a)
    );

    simple_uart #(.CLOCK_FREQUENCY(16000000), .BAUD_RATE(1000000)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .ser_rx         (ser_tx_b),
        .ser_tx         (ser_tx_b),
        .reg_dat_re     (reg_dat_re_b),
        .reg_dat_do     (reg_dat_do_b),
        .recv_buf_valid (recv_buf_valid_b),
        .reg_dat_we     (reg_dat_we_b),
        .reg_dat_di     (reg_dat_di_b),
        .tx_busy        (tx_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drives one frame on ser_rx_a starting at the current negedge. Reports the
    // first cycle within the stop bit at which the receive buffer is valid.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit,
                            input logic hold_re, output int rise_at);
        logic [9:0] fr;
        int         cyc;
        fr      = {stop_bit, b, 1'b0};
        rise_at = -1;
        cyc     = 0;
        for (int k = 0; k < 10; k++) begin
            ser_rx_a = fr[k];
            if (k == 9) reg_dat_re_a = hold_re;
            for (int j = 0; j < DIV_A; j++) begin
                @(negedge clk);
                cyc++;
                if (k == 9 && rise_at < 0 && recv_buf_valid_a) rise_at = cyc;
            end
        end
        reg_dat_re_a = 1'b0;
    endtask

    initial begin
        int         rise;
        int         busy_cnt;
        logic       idle_bad;
        logic       got;
        logic [7:0] b;
        logic [7:0] tx_byte;

        reset        = 1'b1;
        ser_rx_a     = 1'b1;
        reg_dat_re_a = 1'b0;
        reg_dat_we_a = 1'b0;
        reg_dat_di_a = 8'h00;
        reg_dat_re_b = 1'b0;
        reg_dat_we_b = 1'b0;
        reg_dat_di_b = 8'h00;

        wait_cycles(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ser_tx", ser_tx_a, 1);
        chk("rst_tx_busy", tx_busy_a, 0);
        chk("rst_valid", recv_buf_valid_a, 0);
        chk("rst_do", reg_dat_do_a, 8'h00);

        // First byte and receive latency
        exp_q.push_back(8'h90);
        rx_frame(8'h90, 1'b1, 1'b0, rise);
        chk("rx90_latency_ok", (rise >= 4860 && rise <= 4875), 1);
        chk("rx90_valid", recv_buf_valid_a, 1);
        chk("rx90_data", reg_dat_do_a, exp_q.pop_front());

        // Read handshake
        reg_dat_re_a = 1'b1;
        @(negedge clk);
        reg_dat_re_a = 1'b0;
        chk("read_valid_clr", recv_buf_valid_a, 0);
        chk("read_data_kept", reg_dat_do_a, 8'h90);

        // Overrun
        exp_q.push_back(8'h3C);
        rx_frame(8'h3C, 1'b1, 1'b0, rise);
        chk("ovr1_valid", recv_buf_valid_a, 1);
        chk("ovr1_data", reg_dat_do_a, exp_q.pop_front());
        exp_q.push_back(8'h40);
        rx_frame(8'h40, 1'b1, 1'b0, rise);
        chk("ovr2_valid", recv_buf_valid_a, 1);
        chk("ovr2_data", reg_dat_do_a, exp_q.pop_front());

        reg_dat_re_a = 1'b1;
        @(negedge clk);
        reg_dat_re_a = 1'b0;
        chk("read2_valid_clr", recv_buf_valid_a, 0);

        // Glitch rejection
        ser_rx_a = 1'b0;
        wait_cycles(100);
        ser_rx_a = 1'b1;
        wait_cycles(DIV_A + 100);
        chk("glitch_valid", recv_buf_valid_a, 0);
        chk("glitch_data", reg_dat_do_a, 8'h40);

        // Framing error
        rx_frame(8'h55, 1'b0, 1'b0, rise);
        ser_rx_a = 1'b1;
        wait_cycles(50);
        chk("frame_err_valid", recv_buf_valid_a, 0);
        chk("frame_err_data", reg_dat_do_a, 8'h40);

        // Completion coinciding with a held read strobe
        exp_q.push_back(8'h81);
        rx_frame(8'h81, 1'b1, 1'b1, rise);
        chk("simul_valid_seen", (rise >= 0), 1);
        chk("simul_data", reg_dat_do_a, exp_q.pop_front());

        // Transmit A5, with an ignored write during the frame
        tx_byte = 8'hA5;
        txb_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) txb_q.push_back(tx_byte[k]);
        txb_q.push_back(1'b1);
        reg_dat_we_a = 1'b1;
        reg_dat_di_a = tx_byte;
        busy_cnt = 0;
        idle_bad = 1'b0;
        for (int i = 1; i <= 12 * DIV_A; i++) begin
            @(negedge clk);
            reg_dat_we_a = (i == 100);
            reg_dat_di_a = (i == 100) ? 8'hFF : tx_byte;
            if (tx_busy_a) busy_cnt++;
            if (i <= 10 * DIV_A && (i % DIV_A) == DIV_A / 2)
                chk($sformatf("tx_bit%0d", i / DIV_A), ser_tx_a, txb_q.pop_front());
            if (i > 10 * DIV_A && (ser_tx_a !== 1'b1 || tx_busy_a !== 1'b0)) idle_bad = 1'b1;
        end
        chk("tx_busy_cycles", busy_cnt, 10 * DIV_A);
        chk("tx_no_extra_frame", idle_bad, 0);

        // Reset in the middle of TX and RX frames
        reg_dat_we_a = 1'b1;
        reg_dat_di_a = 8'h00;
        ser_rx_a     = 1'b0;
        @(negedge clk);
        reg_dat_we_a = 1'b0;
        wait_cycles(1000);
        chk("pre_rst_ser_tx_low", ser_tx_a, 0);
        reset    = 1'b1;
        ser_rx_a = 1'b1;
        @(negedge clk);
        chk("midrst_ser_tx", ser_tx_a, 1);
        chk("midrst_tx_busy", tx_busy_a, 0);
        chk("midrst_valid", recv_buf_valid_a, 0);
        chk("midrst_do", reg_dat_do_a, 8'h00);
        reset = 1'b0;
        wait_cycles(2 * DIV_A);
        chk("postrst_valid", recv_buf_valid_a, 0);
        chk("postrst_busy", tx_busy_a, 0);

        // Loopback on the DIV=16 instance
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            reg_dat_we_b = 1'b1;
            reg_dat_di_b = b;
            @(negedge clk);
            reg_dat_we_b = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clk);
                got = recv_buf_valid_b;
            end
            chk("lb_valid", got, 1);
            chk("lb_data", reg_dat_do_b, exp_q.pop_front());
            reg_dat_re_b = 1'b1;
            @(negedge clk);
            reg_dat_re_b = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 400 && !got; t++) begin
                got = !tx_busy_b;
                if (!got) @(negedge clk);
            end
            if (!got) chk("lb_busy_timeout", 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
